// File: rtl/ov7670_frame_qualifier.sv
// Frame-geometry checker for the OV7670 capture path: counts bytes per line and lines per frame,
// reports good/bad frames and re-times the CPU freeze request onto vsync rising edges.
module ov7670_frame_qualifier #(
  parameter int unsigned H_BYTES = 1280,
  parameter int unsigned V_LINES = 480,
  parameter int unsigned BC_W    = 11,
  parameter int unsigned LC_W    = 10,
  parameter int unsigned FC_W    = 16
) (
  input  logic            pclk,
  input  logic            reset_n,
  input  logic            vsync,
  input  logic            href,
  input  logic            freeze_req,
  output logic            freeze_frame,
  output logic            frame_done,
  output logic            frame_ok,
  output logic [LC_W-1:0] last_lines,
  output logic            line_err,
  output logic [FC_W-1:0] frame_count
);

  typedef enum logic [1:0] {StWaitVs, StBlank, StActive} state_e;

  state_e          state;
  logic            vsync_d, href_d;
  logic            frz_meta, frz_s;
  logic [BC_W-1:0] byte_cnt;
  logic [LC_W-1:0] line_cnt;
  logic            err_acc;

  logic            vs_rise, vs_fall, href_fall;
  logic [BC_W-1:0] byte_inc;
  logic [LC_W-1:0] line_inc;
  logic            line_bad;
  logic [LC_W-1:0] lines_eval;
  logic            err_eval;
  logic            ok_eval;

  always_comb begin
    vs_rise   = vsync & ~vsync_d;
    vs_fall   = ~vsync & vsync_d;
    href_fall = ~href & href_d;
    byte_inc  = (byte_cnt == '1) ? byte_cnt : byte_cnt + 1'b1;
    line_inc  = (line_cnt == '1) ? line_cnt : line_cnt + 1'b1;
    line_bad  = (byte_cnt != BC_W'(H_BYTES));
    // A line ending on the same edge vsync rises is folded into the evaluation.
    lines_eval = href_fall ? line_inc : line_cnt;
    err_eval   = err_acc | (href_fall & line_bad);
    ok_eval    = (lines_eval == LC_W'(V_LINES)) & ~err_eval;
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= StWaitVs;
      vsync_d      <= 1'b0;
      href_d       <= 1'b0;
      frz_meta     <= 1'b0;
      frz_s        <= 1'b0;
      byte_cnt     <= '0;
      line_cnt     <= '0;
      err_acc      <= 1'b0;
      freeze_frame <= 1'b0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      last_lines   <= '0;
      line_err     <= 1'b0;
      frame_count  <= '0;
    end else begin
      vsync_d    <= vsync;
      href_d     <= href;
      frz_meta   <= freeze_req;
      frz_s      <= frz_meta;
      frame_done <= 1'b0;
      if (vs_rise) freeze_frame <= frz_s;
      case (state)
        StWaitVs: begin
          if (vs_rise) state <= StBlank;
        end
        StBlank: begin
          if (vs_fall) begin
            state    <= StActive;
            byte_cnt <= '0;
            line_cnt <= '0;
            err_acc  <= 1'b0;
          end
        end
        StActive: begin
          if (href) byte_cnt <= byte_inc;
          if (href_fall) begin
            line_cnt <= line_inc;
            byte_cnt <= '0;
            if (line_bad) err_acc <= 1'b1;
          end
          if (vs_rise) begin
            state       <= StBlank;
            frame_done  <= 1'b1;
            last_lines  <= lines_eval;
            line_err    <= err_eval;
            frame_ok    <= ok_eval;
            frame_count <= frame_count + FC_W'(ok_eval);
          end
        end
        default: state <= StWaitVs;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_frame_qualifier.sv
// Bench for ov7670_frame_qualifier: directed table of frames, random frames against a
// line-length model, freeze re-timing, counter wrap and asynchronous reset.
module tb_ov7670_frame_qualifier;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int BC = 4;
  localparam int LC = 4;
  localparam int FC = 3;

  logic          pclk = 1'b0;
  logic          reset_n = 1'b0;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic          freeze_req = 1'b0;
  logic          freeze_frame, frame_done, frame_ok, line_err;
  logic [LC-1:0] last_lines;
  logic [FC-1:0] frame_count;

  ov7670_frame_qualifier #(
    .H_BYTES(H), .V_LINES(V), .BC_W(BC), .LC_W(LC), .FC_W(FC)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .vsync(vsync), .href(href), .freeze_req(freeze_req),
    .freeze_frame(freeze_frame), .frame_done(frame_done), .frame_ok(frame_ok),
    .last_lines(last_lines), .line_err(line_err), .frame_count(frame_count)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int             n;
    logic [7:0][7:0] lens;
    bit             simul;
    bit             ok;
    int             lines;
    bit             err;
  } vec_t;

  vec_t vecs[5];
  int   n_checks = 0;
  int   n_fail = 0;
  int   pulses = 0;
  int   exp_pulses = 0;
  int   exp_count = 0;
  bit   exp_frz = 1'b0;

  always @(negedge pclk) if (frame_done) pulses++;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic h);
    vsync = v;
    href  = h;
    @(posedge pclk);
    #1;
  endtask

  function automatic logic [7:0][7:0] mk(input int a, b, c, d, e, f);
    logic [7:0][7:0] l;
    l = '0;
    l[0] = 8'(a); l[1] = 8'(b); l[2] = 8'(c); l[3] = 8'(d); l[4] = 8'(e); l[5] = 8'(f);
    return l;
  endfunction

  // Frame judged purely from its list of line lengths, with counter saturation.
  task automatic model(input int n, input logic [7:0][7:0] lens,
                       output bit ok, output int lines, output bit err);
    int lmax, bmax;
    lmax  = (1 << LC) - 1;
    bmax  = (1 << BC) - 1;
    lines = (n > lmax) ? lmax : n;
    err   = 1'b0;
    for (int i = 0; i < n; i++) begin
      int len;
      len = int'(lens[i]);
      if (len > bmax) len = bmax;
      if (len != H) err = 1'b1;
    end
    ok = (lines == V) && !err;
  endtask

  // Starts in vertical blank, ends in vertical blank after the evaluation is checked.
  task automatic run_frame(input int n, input logic [7:0][7:0] lens, input bit simul,
                           input int frz, input bit e_ok, input int e_lines, input bit e_err);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < int'(lens[i]); b++) cyc(1'b0, 1'b1);
      if (!(simul && i == n - 1)) begin
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
      end
      if (i == 0 && frz >= 0) freeze_req = frz[0];
    end
    chk("freeze_hold", freeze_frame, exp_frz);
    cyc(1'b1, 1'b0);
    exp_frz    = freeze_req;
    exp_count  = (exp_count + int'(e_ok)) % (1 << FC);
    exp_pulses++;
    chk("frame_done", frame_done, 1);
    chk("frame_ok", frame_ok, e_ok);
    chk("last_lines", last_lines, e_lines);
    chk("line_err", line_err, e_err);
    chk("frame_count", frame_count, exp_count);
    chk("freeze_frame", freeze_frame, exp_frz);
    cyc(1'b1, 1'b0);
    chk("done_one_cycle", frame_done, 0);
    chk("pulse_count", pulses, exp_pulses);
    cyc(1'b1, 1'b0);
  endtask

  task automatic good_frame(input int frz);
    run_frame(4, mk(8, 8, 8, 8, 0, 0), 1'b0, frz, 1'b1, 4, 1'b0);
  endtask

  task automatic line8();
    for (int b = 0; b < 8; b++) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{n: 4, lens: mk(8, 7, 8, 8, 0, 0), simul: 1'b0, ok: 1'b0, lines: 4, err: 1'b1};
    vecs[1] = '{n: 5, lens: mk(8, 8, 8, 8, 8, 0), simul: 1'b0, ok: 1'b0, lines: 5, err: 1'b0};
    vecs[2] = '{n: 4, lens: mk(8, 8, 8, 8, 0, 0), simul: 1'b1, ok: 1'b1, lines: 4, err: 1'b0};
    vecs[3] = '{n: 3, lens: mk(8, 8, 8, 0, 0, 0), simul: 1'b0, ok: 1'b0, lines: 3, err: 1'b0};
    vecs[4] = '{n: 4, lens: mk(8, 8, 8, 9, 0, 0), simul: 1'b1, ok: 1'b0, lines: 4, err: 1'b1};

    // Reset held during an active frame, released mid-line.
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_last_lines", last_lines, 0);
    chk("rst_line_err", line_err, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_freeze", freeze_frame, 0);
    reset_n = 1'b1;
    for (int b = 0; b < 5; b++) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    line8();
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("no_partial_pulse", pulses, 0);
    good_frame(-1);

    foreach (vecs[k])
      run_frame(vecs[k].n, vecs[k].lens, vecs[k].simul, -1, vecs[k].ok, vecs[k].lines,
                vecs[k].err);

    // Freeze raised then dropped mid-frame; only vsync rising edges move the output.
    good_frame(1);
    good_frame(0);

    for (int r = 0; r < 12; r++) begin
      int              n;
      logic [7:0][7:0] lens;
      bit              ok, err, simul;
      int              lines;
      n     = $urandom_range(3, 5);
      lens  = '0;
      simul = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++)
        lens[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(6, 10)) : 8'd8;
      model(n, lens, ok, lines, err);
      run_frame(n, lens, simul, -1, ok, lines, err);
    end

    for (int k = 0; k < 8 && exp_count != (1 << FC) - 1; k++) good_frame(-1);
    chk("count_at_max", frame_count, (1 << FC) - 1);
    good_frame(1);

    // Asynchronous reset mid-frame clears everything between clock edges.
    cyc(1'b0, 1'b0);
    line8();
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    #2;
    reset_n    = 1'b0;
    freeze_req = 1'b0;
    #1;
    chk("arst_frame_done", frame_done, 0);
    chk("arst_frame_ok", frame_ok, 0);
    chk("arst_last_lines", last_lines, 0);
    chk("arst_line_err", line_err, 0);
    chk("arst_frame_count", frame_count, 0);
    chk("arst_freeze", freeze_frame, 0);
    @(posedge pclk);
    #1;
    reset_n   = 1'b1;
    exp_count = 0;
    exp_frz   = 1'b0;
    for (int b = 0; b < 5; b++) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    line8();
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("no_pulse_after_arst", pulses, exp_pulses);
    chk("ok_cleared_after_arst", frame_ok, 0);
    good_frame(-1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
